// File: rtl/alu_exec_stage_if.sv
// Operand/control bus into the execute stage and its result bus back to the datapath.
// The DUT connects through the slave modport; the control/datapath side uses master.
interface alu_exec_stage_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  Funct;
    logic [1:0]  ALUOp;
    logic [5:0]  ALUCtrl;
    logic [31:0] C;
    logic        Zero;
    logic        Overflow;
    logic [31:0] C_reg;

    modport master (
        output A, B, Funct, ALUOp,
        input  ALUCtrl, C, Zero, Overflow, C_reg
    );

    modport slave (
        input  A, B, Funct, ALUOp,
        output ALUCtrl, C, Zero, Overflow, C_reg
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage of the multi-cycle datapath: ALU control decode, 32-bit combinational ALU,
// and the ALUOut holding register, which always captures C one cycle behind.
module alu_exec_stage (
    input  logic               CLK,
    input  logic               RST,
    alu_exec_stage_if.slave    bus
);
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_ADDU = 6'b100001;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_SUBU = 6'b100011;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;
    localparam logic [5:0] OP_EQ   = 6'b111110;

    logic [5:0]  alu_ctrl;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic [31:0] result;
    logic        ovf;
    logic [31:0] result_q;

    always_comb begin
        alu_ctrl = OP_ADD;
        case (bus.ALUOp)
            2'b00:   alu_ctrl = OP_ADD;
            2'b01:   alu_ctrl = OP_EQ;
            2'b10:   alu_ctrl = bus.Funct;
            default: alu_ctrl = OP_OR;
        endcase
    end

    assign sum  = bus.A + bus.B;
    assign diff = bus.A - bus.B;
    // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
    assign add_ovf = (bus.A[31] == bus.B[31]) && (sum[31]  != bus.A[31]);
    assign sub_ovf = (bus.A[31] != bus.B[31]) && (diff[31] != bus.A[31]);

    always_comb begin
        result = 32'd0;
        ovf    = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                result = sum;
                ovf    = add_ovf;
            end
            OP_ADDU: result = sum;
            OP_SUB: begin
                result = diff;
                ovf    = sub_ovf;
            end
            OP_SUBU: result = diff;
            OP_AND:  result = bus.A & bus.B;
            OP_OR:   result = bus.A | bus.B;
            OP_XOR:  result = bus.A ^ bus.B;
            OP_NOR:  result = ~(bus.A | bus.B);
            OP_SLT:  result = {31'd0, $signed(bus.A) < $signed(bus.B)};
            OP_SLTU: result = {31'd0, bus.A < bus.B};
            OP_EQ:   result = {31'd0, bus.A == bus.B};
            default: begin
                result = 32'd0;
                ovf    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_q <= 32'd0;
        end else begin
            result_q <= result;
        end
    end

    assign bus.ALUCtrl  = alu_ctrl;
    assign bus.C        = result;
    assign bus.Zero     = (result == 32'd0);
    assign bus.Overflow = ovf;
    assign bus.C_reg    = result_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: reset, branch compare, R-type sweep, overflow,
// default decode paths and the one-cycle ALUOut pipeline.
module tb_alu_exec_stage;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_exec_stage_if bus ();

    alu_exec_stage dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        bus.ALUOp = op;
        bus.Funct = fn;
        bus.A     = a;
        bus.B     = b;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (bus.C_reg !== 32'd0) begin
            n_err++;
            $display("FAIL reset_init C_reg got %h want %h", bus.C_reg, 32'd0);
        end
        RST = 1'b0;
        drive(2'b00, 6'd0, 32'h1230, 32'h4);
        @(posedge CLK); #1;
        n_cmp++;
        if (bus.C_reg !== 32'h1234) begin
            n_err++;
            $display("FAIL reset_preload C_reg got %h want %h", bus.C_reg, 32'h1234);
        end
        #1 RST = 1'b1;
        #1;
        n_cmp++;
        if (bus.C_reg !== 32'd0) begin
            n_err++;
            $display("FAIL reset_async C_reg got %h want %h", bus.C_reg, 32'd0);
        end
        n_cmp++;
        if (bus.C !== 32'h1234) begin
            n_err++;
            $display("FAIL reset_comb_unaffected C got %h want %h", bus.C, 32'h1234);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (bus.C_reg !== 32'd0) begin
            n_err++;
            $display("FAIL reset_hold C_reg got %h want %h", bus.C_reg, 32'd0);
        end
        @(negedge CLK);
        RST = 1'b0;
        drive(2'b00, 6'd0, 32'd5, 32'd3);
        n_cmp++;
        if (bus.C !== 32'd8) begin
            n_err++;
            $display("FAIL release_comb C got %h want %h", bus.C, 32'd8);
        end
        n_cmp++;
        if (bus.C_reg !== 32'd0) begin
            n_err++;
            $display("FAIL release_before_edge C_reg got %h want %h", bus.C_reg, 32'd0);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (bus.C_reg !== 32'd8) begin
            n_err++;
            $display("FAIL release_capture C_reg got %h want %h", bus.C_reg, 32'd8);
        end
    endtask

    task automatic test_branch();
        @(negedge CLK);
        drive(2'b01, 6'd0, 32'hDEADBEEF, 32'hDEADBEEF);
        n_cmp++;
        if (bus.ALUCtrl !== 6'b111110) begin
            n_err++;
            $display("FAIL branch_ctrl ALUCtrl got %b want %b", bus.ALUCtrl, 6'b111110);
        end
        n_cmp++;
        if (bus.C !== 32'd1 || bus.Zero !== 1'b0) begin
            n_err++;
            $display("FAIL branch_eq C/Zero got %h/%b want %h/%b", bus.C, bus.Zero, 32'd1, 1'b0);
        end
        drive(2'b01, 6'd0, 32'hDEADBEEF, 32'hDEADBEEE);
        n_cmp++;
        if (bus.C !== 32'd0 || bus.Zero !== 1'b1) begin
            n_err++;
            $display("FAIL branch_ne C/Zero got %h/%b want %h/%b", bus.C, bus.Zero, 32'd0, 1'b1);
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn  [6] = '{6'b100010, 6'b101010, 6'b101011, 6'b100111, 6'b100100, 6'b100110};
        logic [31:0] exp [6] = '{32'h80000001, 32'd1, 32'd1, 32'd0, 32'h80000000, 32'h7FFFFFFF};
        for (int i = 0; i < 6; i++) begin
            drive(2'b10, fn[i], 32'h80000000, 32'hFFFFFFFF);
            n_cmp++;
            if (bus.C !== exp[i] || bus.Overflow !== 1'b0 || bus.ALUCtrl !== fn[i]) begin
                n_err++;
                $display("FAIL rtype_%b C/Ovf/Ctrl got %h/%b/%b want %h/0/%b",
                         fn[i], bus.C, bus.Overflow, bus.ALUCtrl, exp[i], fn[i]);
            end
        end
        // SUBU and SLT/SLTU diverge when operand signs differ.
        drive(2'b10, 6'b101010, 32'h00000001, 32'hFFFFFFFF);
        n_cmp++;
        if (bus.C !== 32'd0) begin
            n_err++;
            $display("FAIL slt_pos_vs_neg C got %h want %h", bus.C, 32'd0);
        end
        drive(2'b10, 6'b101011, 32'h00000001, 32'hFFFFFFFF);
        n_cmp++;
        if (bus.C !== 32'd1) begin
            n_err++;
            $display("FAIL sltu_pos_vs_big C got %h want %h", bus.C, 32'd1);
        end
        drive(2'b10, 6'b100011, 32'h80000000, 32'h00000001);
        n_cmp++;
        if (bus.C !== 32'h7FFFFFFF || bus.Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL subu C/Ovf got %h/%b want %h/0", bus.C, bus.Overflow, 32'h7FFFFFFF);
        end
    endtask

    task automatic test_overflow();
        drive(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h7FFFFFFF);
        n_cmp++;
        if (bus.C !== 32'hFFFFFFFE || bus.Overflow !== 1'b1) begin
            n_err++;
            $display("FAIL add_ovf C/Ovf got %h/%b want %h/1", bus.C, bus.Overflow, 32'hFFFFFFFE);
        end
        drive(2'b10, 6'b100001, 32'h7FFFFFFF, 32'h7FFFFFFF);
        n_cmp++;
        if (bus.C !== 32'hFFFFFFFE || bus.Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL addu_no_ovf C/Ovf got %h/%b want %h/0", bus.C, bus.Overflow, 32'hFFFFFFFE);
        end
        drive(2'b10, 6'b100010, 32'h80000000, 32'h00000001);
        n_cmp++;
        if (bus.C !== 32'h7FFFFFFF || bus.Overflow !== 1'b1) begin
            n_err++;
            $display("FAIL sub_ovf C/Ovf got %h/%b want %h/1", bus.C, bus.Overflow, 32'h7FFFFFFF);
        end
        drive(2'b00, 6'b000000, 32'h7FFFFFFF, 32'h00000001);
        n_cmp++;
        if (bus.C !== 32'h80000000 || bus.Overflow !== 1'b1) begin
            n_err++;
            $display("FAIL aluop00_ovf C/Ovf got %h/%b want %h/1", bus.C, bus.Overflow, 32'h80000000);
        end
    endtask

    task automatic test_defaults();
        drive(2'b11, 6'b000000, 32'hF0, 32'h0F);
        n_cmp++;
        if (bus.C !== 32'hFF || bus.ALUCtrl !== 6'b100101) begin
            n_err++;
            $display("FAIL aluop11_or C/Ctrl got %h/%b want %h/%b", bus.C, bus.ALUCtrl, 32'hFF, 6'b100101);
        end
        drive(2'b10, 6'b000111, 32'hF0, 32'h0F);
        n_cmp++;
        if (bus.C !== 32'd0 || bus.Zero !== 1'b1 || bus.Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL unknown_funct C/Zero/Ovf got %h/%b/%b want 0/1/0", bus.C, bus.Zero, bus.Overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3] = '{32'd1, 32'd2, 32'd3};
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 6'd0, vals[i] - 32'd1, 32'd1);
            @(posedge CLK); #1;
            n_cmp++;
            if (bus.C_reg !== vals[i]) begin
                n_err++;
                $display("FAIL pipe_%0d C_reg got %h want %h", i, bus.C_reg, vals[i]);
            end
            @(negedge CLK);
        end
        drive(2'b00, 6'd0, 32'd100, 32'd0);
        n_cmp++;
        if (bus.C_reg !== 32'd3) begin
            n_err++;
            $display("FAIL pipe_lag C_reg got %h want %h", bus.C_reg, 32'd3);
        end
    endtask

    initial begin
        bus.A = '0;
        bus.B = '0;
        bus.Funct = '0;
        bus.ALUOp = '0;
        test_reset();
        test_branch();
        test_rtype();
        test_overflow();
        test_defaults();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage arithmetic block of the multi-cycle CPU datapath. It merges three functions: ALU control decode (2-bit ALUOp from the main control unit plus the instruction funct field), a 32-bit combinational ALU, and the ALUOut holding register. The combinational result feeds the PC-input mux and the branch-write qualifier (result bit 0). The registered result feeds the register-file write-data mux and the memory-address mux in the next state.

## Interface
- No parameters; widths fixed at 32-bit data, 6-bit control.
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset; clears C_reg
- A  in  32  operand A (PC or register data 1, muxed upstream)
- B  in  32  operand B (reg data 2, 4, sign-ext imm, or imm<<2)
- Funct  in  6  instruction bits [5:0]
- ALUOp  in  2  ALU operation class from main control
- ALUCtrl  out  6  decoded ALU operation code
- C  out  32  combinational ALU result
- Zero  out  1  high when C == 0
- Overflow  out  1  signed overflow for ADD/SUB codes only, else 0
- C_reg  out  32  registered copy of C (ALUOut)

## Operation
- Decode (combinational):
  - ALUOp 00 → ADD 100000 (address calc, PC+4)
  - ALUOp 01 → EQ 111110 (branch compare)
  - ALUOp 10 → ALUCtrl = Funct (R-type)
  - ALUOp 11 → OR 100101
- ALU (combinational, by ALUCtrl):
  - 100000 ADD: A+B, mod 2^32; Overflow = signed overflow
  - 100001 ADDU: A+B; Overflow 0
  - 100010 SUB: A−B; Overflow = signed overflow
  - 100011 SUBU: A−B; Overflow 0
  - 100100 AND: A&B
  - 100101 OR: A|B
  - 100110 XOR: A^B
  - 100111 NOR: ~(A|B)
  - 101010 SLT: {31'b0, signed A<B}
  - 101011 SLTU: {31'b0, unsigned A<B}
  - 111110 EQ: {31'b0, A==B}; bit 0 is the branch-taken qualifier
  - any other code: C = 0, Overflow = 0
- Overflow never blocks or alters C; it is reported only.
- Zero is derived from C for every code.

## Timing
- ALUCtrl, C, Zero and Overflow are purely combinational from A, B, Funct and ALUOp, with zero-cycle latency.
- C_reg <= C on every rising CLK edge. There is no enable; C_reg is always one cycle behind C.
- RST asserted: C_reg = 0 immediately, independent of CLK. It holds 0 while RST is high. The first capture happens on the first rising edge after RST is deasserted.
- RST is asserted mid-operation: the in-flight result is lost, and the combinational outputs are unaffected.
- Operand change between edges: only the value present at the edge is captured. Glitches on C are tolerated downstream.

## Test plan
- Reset: RST=1 with C_reg previously 0x1234 → C_reg=0 with no clock edge. Release RST with A=5, B=3, ALUOp=00 → C=8 at once, C_reg=8 after one edge.
- Branch compare: ALUOp=01, A=B=0xDEADBEEF → ALUCtrl=111110, C=1. With B=0xDEADBEEE → C=0, Zero=1.
- R-type sweep: ALUOp=10, A=0x80000000, B=0xFFFFFFFF.
  - Funct 100010 → C=0x80000001, Overflow=0.
  - Funct 101010 → C=1.
  - Funct 101011 → C=1.
  - Funct 100111 → C=0.
- Overflow: ALUOp=10, Funct=100000, A=B=0x7FFFFFFF → C=0xFFFFFFFE, Overflow=1. Funct=100001 with the same operands → Overflow=0.
- Default paths: ALUOp=11, A=0xF0, B=0x0F → C=0xFF. ALUOp=10, Funct=000111 → C=0, Zero=1.
- Pipeline hold: apply A+B values 1, 2, 3 on successive cycles → C_reg shows 1, 2, 3, each one edge late.
